// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Memory-side responder for the cache arbiter's line interface. Takes one
//   256-bit line read or write at a time and turns it into a 4-beat x 64-bit
//   burst toward physical memory, then pulses resp_o for one cycle.
//
// Ports
//   clk, rst     clock (posedge) and asynchronous active-high reset
//   line_i       write line from arbiter, sampled when the request is accepted
//   line_o       read line to arbiter, valid only while resp_o=1 after a read
//   address_i    line address from arbiter, sampled when the request is accepted
//   read_i       line read request (level, held until resp_o)
//   write_i      line write request (level, held until resp_o)
//   resp_o       one-cycle completion pulse
//   burst_i      read beat from memory, valid when resp_i=1
//   burst_o      current write beat to memory
//   address_o    line-aligned burst address, nonzero only while bursting
//   read_o       burst read request to memory
//   write_o      burst write request to memory
//   resp_i       memory beat strobe, one per beat, gaps allowed
//
// Handshake: the arbiter raises read_i or write_i and holds it; the request is
// accepted in IDLE on the next clock (write wins over read). Memory sees read_o
// or write_o held for the whole burst and acknowledges each beat with a
// one-cycle resp_i; a cycle without resp_i stalls the beat counter. After the
// last beat the block spends one cycle in DONE with resp_o=1, ignoring the
// still-held request, and then returns to IDLE.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [BEATS-1:0][BURST_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  // Remembers whether the finished burst was a read, so line_o is only
  // driven in DONE after a read.
  logic                            is_rd_q, is_rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    is_rd_d = is_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (write_i) begin
          buf_d   = line_i;
          addr_d  = address_i;
          is_rd_d = 1'b0;
          state_d = ST_WR;
        end else if (read_i) begin
          addr_d  = address_i;
          is_rd_d = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (resp_i) begin
          buf_d[cnt_q] = burst_i;
          // Counter wraps to 0 on the last beat, ready for the next burst.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_DONE;
        end
      end
      ST_WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so an asynchronous reset clears
  // them immediately.
  always_comb begin
    read_o    = (state_q == ST_RD);
    write_o   = (state_q == ST_WR);
    resp_o    = (state_q == ST_DONE);
    address_o = '0;
    burst_o   = '0;
    line_o    = '0;
    if (state_q == ST_RD || state_q == ST_WR) begin
      address_o = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
    if (state_q == ST_WR) begin
      burst_o = buf_q[cnt_q];
    end
    if (state_q == ST_DONE && is_rd_q) begin
      line_o = buf_q;
    end
  end

endmodule
